// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready flow control.
// Subnormal results are flushed to zero; an all-ones exponent operand forces the exception code.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   isSub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   exception,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = MAN_W + 3;
  localparam int SW = MAN_W + 5;
  localparam int LW = $clog2(SW);
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: swap and align ----------------
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;

  logic               swap, sign_c, sub_c, exc_c, st_c;
  logic [EXP_W-1:0]   e_big, e_sml, e_big_eff, e_sml_eff, diff;
  logic [AW-1:0]      m_big_x, m_sml_x, m_aln;
  logic [2*AW-1:0]    shv;

  always_comb begin
    swap      = {eb, mb} > {ea, ma};
    e_big     = swap ? eb : ea;
    e_sml     = swap ? ea : eb;
    m_big_x   = {|e_big, (swap ? mb : ma), 2'b00};
    m_sml_x   = {|e_sml, (swap ? ma : mb), 2'b00};
    e_big_eff = (e_big == '0) ? EXP_W'(1) : e_big;
    e_sml_eff = (e_sml == '0) ? EXP_W'(1) : e_sml;
    diff      = e_big_eff - e_sml_eff;
    // Upper half is the aligned mantissa, lower half collects shifted-out bits for sticky.
    shv       = {m_sml_x, {AW{1'b0}}} >> diff;
    if (32'(diff) >= AW) begin
      m_aln = '0;
      st_c  = |m_sml_x;
    end else begin
      m_aln = shv[2*AW-1:AW];
      st_c  = |shv[AW-1:0];
    end
    sub_c  = sa ^ sb ^ isSub;
    sign_c = swap ? (sb ^ isSub) : sa;
    exc_c  = (&ea) | (&eb);
  end

  logic               s1_v, s1_sign, s1_sub, s1_exc, s1_st;
  logic [EXP_W-1:0]   s1_exp;
  logic [AW-1:0]      s1_ma, s1_mb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_sub  <= 1'b0;
      s1_exc  <= 1'b0;
      s1_st   <= 1'b0;
      s1_exp  <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
    end else if (adv) begin
      s1_v    <= in_valid;
      s1_sign <= sign_c;
      s1_sub  <= sub_c;
      s1_exc  <= exc_c;
      s1_st   <= st_c;
      s1_exp  <= e_big_eff;
      s1_ma   <= m_big_x;
      s1_mb   <= m_aln;
    end
  end

  // ---------------- S2: mantissa add / subtract ----------------
  logic [SW-1:0] op_a, op_b, m_c;
  assign op_a = {1'b0, s1_ma, 1'b0};
  assign op_b = {1'b0, s1_mb, s1_st};
  assign m_c  = s1_sub ? (op_a - op_b) : (op_a + op_b);

  logic               s2_v, s2_sign, s2_exc;
  logic [EXP_W-1:0]   s2_exp;
  logic [SW-1:0]      s2_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_sign <= 1'b0;
      s2_exc  <= 1'b0;
      s2_exp  <= '0;
      s2_m    <= '0;
    end else if (adv) begin
      s2_v    <= s1_v;
      s2_sign <= s1_sign;
      s2_exc  <= s1_exc;
      s2_exp  <= s1_exp;
      s2_m    <= m_c;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LW-1:0]        lzc;
  logic [SW-2:0]        nv;
  logic [XW-1:0]        exp_n, exp_f;
  logic [MAN_W+1:0]     mr;
  logic [MAN_W-1:0]     man_f;
  logic                 rnd, uf_c, ov_c, exc_o, ov_o, uf_o;
  logic [EXP_W+MAN_W:0] res_c;

  always_comb begin
    lzc = LW'(SW - 1);
    for (int unsigned i = 0; i < SW - 1; i++) begin
      if (s2_m[i]) lzc = LW'(SW - 2 - i);
    end
    if (s2_m[SW-1]) begin
      nv    = {s2_m[SW-1:2], s2_m[1] | s2_m[0]};
      exp_n = XW'(s2_exp) + XW'(1);
    end else begin
      nv    = s2_m[SW-2:0] << lzc;
      exp_n = XW'(s2_exp) - XW'(lzc);
    end
    uf_c  = exp_n[XW-1] || (exp_n == '0);
    rnd   = nv[2] & (nv[1] | nv[0] | nv[3]);
    mr    = {1'b0, nv[SW-2:3]} + (MAN_W+2)'(rnd);
    exp_f = mr[MAN_W+1] ? exp_n + XW'(1) : exp_n;
    man_f = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    ov_c  = exp_f >= EMAX;

    res_c = '0;
    exc_o = 1'b0;
    ov_o  = 1'b0;
    uf_o  = 1'b0;
    if (s2_exc) begin
      res_c = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      exc_o = 1'b1;
    end else if (s2_m == '0) begin
      res_c = '0;
    end else if (uf_c) begin
      res_c = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
      uf_o  = 1'b1;
    end else if (ov_c) begin
      res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ov_o  = 1'b1;
    end else begin
      res_c = {s2_sign, exp_f[EXP_W-1:0], man_f};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      exception <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_v;
      result    <= s2_v ? res_c : '0;
      exception <= s2_v & exc_o;
      overflow  <= s2_v & ov_o;
      underflow <= s2_v & uf_o;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: hand-computed vector table driven through a scoreboard,
// plus latency, back-pressure and mid-flight reset sequences.
module tb_fp_addsub_pipe;

  typedef struct packed {
    logic [18:0] res;
    logic        exc;
    logic        ov;
    logic        uf;
  } exp_t;

  typedef struct packed {
    logic [18:0] a;
    logic [18:0] b;
    logic        sub;
    exp_t        e;
  } vec_t;

  localparam int NV = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, isSub;
  logic        out_valid, out_ready;
  logic [18:0] a, b, result;
  logic        exception, overflow, underflow;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .isSub     (isSub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .exception (exception),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  vec_t tbl [NV];
  exp_t sb_q [$];
  exp_t cur_exp;
  int   n_pass = 0;
  int   n_total = 0;
  int   delivered = 0;
  bit   saw_low = 1'b0;

  function automatic vec_t mk(input logic [18:0] a_, input logic [18:0] b_, input logic s_,
                              input logic [18:0] r_, input logic x_, input logic o_, input logic u_);
    vec_t v;
    v.a     = a_;
    v.b     = b_;
    v.sub   = s_;
    v.e.res = r_;
    v.e.exc = x_;
    v.e.ov  = o_;
    v.e.uf  = u_;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
  endtask

  task automatic monitor();
    bit          prev_stall = 1'b0;
    logic [21:0] prev_val = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        prev_stall = 1'b0;
      end else begin
        check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (!out_valid) check("idle_flags", 32'({exception, overflow, underflow}), 32'(0));
        if (prev_stall) check("stall_hold", 32'({result, exception, overflow, underflow}), 32'(prev_val));
        if (out_valid && !out_ready && !in_ready) saw_low = 1'b1;
        if (in_valid && in_ready) sb_q.push_back(cur_exp);
        if (out_valid && out_ready) begin
          delivered++;
          if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL spurious_result: got 0x%05h with no operation pending", result);
          end else begin
            e = sb_q.pop_front();
            check("result", 32'({result, exception, overflow, underflow}), 32'(e));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_val   = {result, exception, overflow, underflow};
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v);
    bit got = 1'b0;
    a        = v.a;
    b        = v.b;
    isSub    = v.sub;
    cur_exp  = v.e;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, want acceptance");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, want completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int d0;
    bit seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    isSub     = 1'b0;
    out_ready = 1'b1;
    cur_exp   = '0;

    tbl[0]  = mk(19'h1FC00, 19'h1FC00, 1'b0, 19'h20000, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(19'h1FC00, 19'h1FC00, 1'b1, 19'h00000, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(19'h1FC00, 19'h20000, 1'b1, 19'h5FC00, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(19'h3FBFF, 19'h3FBFF, 1'b0, 19'h3FC00, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(19'h3FC00, 19'h1FC00, 1'b0, 19'h3FC00, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(19'h1FC00, 19'h1F800, 1'b0, 19'h1FE00, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(19'h20000, 19'h1F800, 1'b1, 19'h1FE00, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(19'h5FC00, 19'h5FC00, 1'b0, 19'h60000, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(19'h1FC00, 19'h5FC00, 1'b1, 19'h20000, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(19'h1FC00, 19'h1D000, 1'b0, 19'h1FC00, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(19'h1FC01, 19'h1D000, 1'b0, 19'h1FC02, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(19'h1FC00, 19'h1D200, 1'b0, 19'h1FC01, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(19'h1FFFF, 19'h1D000, 1'b0, 19'h20000, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(19'h00401, 19'h00400, 1'b1, 19'h00000, 1'b0, 1'b0, 1'b1);
    tbl[14] = mk(19'h40401, 19'h40400, 1'b1, 19'h40000, 1'b0, 1'b0, 1'b1);
    tbl[15] = mk(19'h1FC00, 19'h00400, 1'b1, 19'h1FC00, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(19'h00000, 19'h00000, 1'b0, 19'h00000, 1'b0, 1'b0, 1'b0);
    tbl[17] = mk(19'h3FBFF, 19'h3CC00, 1'b0, 19'h3FC00, 1'b0, 1'b1, 1'b0);
    tbl[18] = mk(19'h5FC00, 19'h60000, 1'b1, 19'h1FC00, 1'b0, 1'b0, 1'b0);
    tbl[19] = mk(19'h1F800, 19'h60000, 1'b0, 19'h5FE00, 1'b0, 1'b0, 1'b0);
    tbl[20] = mk(19'h1FC00, 19'h3FC01, 1'b0, 19'h3FC00, 1'b1, 1'b0, 1'b0);

    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_flags", 32'({exception, overflow, underflow}), 32'(0));

    fork monitor(); join_none

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(in_ready), 32'(1));

    // Unstalled latency from accepting cycle to out_valid.
    send(tbl[0]);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = out_valid;
    end
    check("latency", 32'(lat), 32'(3));
    @(posedge clk);
    #1;
    drain();

    // Whole table back-to-back.
    d0 = delivered;
    for (int i = 0; i < NV; i++) send(tbl[i]);
    drain();
    check("table_count", 32'(delivered - d0), 32'(NV));

    // Eight-op stream with a 4-cycle downstream stall mid-stream.
    d0      = delivered;
    saw_low = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send(tbl[k]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 32'(delivered - d0), 32'(8));
    check("ready_dropped", 32'(saw_low), 32'(1));

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[5]);
    @(posedge clk);
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'(1));
    #1 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'(0));
    check("async_rst_result", 32'({result, exception, overflow, underflow}), 32'(0));
    d0 = delivered;
    @(negedge clk);
    #2;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_mid_rst", 32'(in_ready), 32'(1));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("no_stale_valid", 32'(out_valid), 32'(0));
    end
    check("no_stale_count", 32'(delivered - d0), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
